// File: rtl/parking_spot_bank_pkg.sv
// Shared constants, spot-state encoding and LED patterns for the parking spot bank.
// The light-pattern helper maps a stored one-hot vehicle size to its LED bar.
package parking_pkg;

    localparam int NUM_SPOTS = 9;
    localparam int TIME_W    = 9;
    localparam int LIGHT_W   = 10;

    localparam logic [2:0] SIZE_CAR = 3'b001;
    localparam logic [2:0] SIZE_VAN = 3'b010;
    localparam logic [2:0] SIZE_BUS = 3'b100;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_BILLING  = 2'd2
    } spot_state_e;

    localparam logic [LIGHT_W-1:0] LIGHT_OFF   = 10'b0000000000;
    localparam logic [LIGHT_W-1:0] LIGHT_CAR   = 10'b0000000011;
    localparam logic [LIGHT_W-1:0] LIGHT_VAN   = 10'b0000001111;
    localparam logic [LIGHT_W-1:0] LIGHT_BUS   = 10'b0000111111;
    localparam logic [LIGHT_W-1:0] LIGHT_OTHER = 10'b0000000001;
    localparam logic [LIGHT_W-1:0] LIGHT_ALL   = 10'b1111111111;

    function automatic logic [LIGHT_W-1:0] size_bar(input logic [2:0] size);
        logic [LIGHT_W-1:0] bar;
        case (size)
            SIZE_CAR: bar = LIGHT_CAR;
            SIZE_VAN: bar = LIGHT_VAN;
            SIZE_BUS: bar = LIGHT_BUS;
            default:  bar = LIGHT_OTHER;
        endcase
        return bar;
    endfunction

endpackage

// File: rtl/parking_spot_bank_cell.sv
// One parking spot: EMPTY -> OCCUPIED -> BILLING -> EMPTY, driven by single-cycle edge pulses.
// occupied_next exposes the upcoming occupancy so the bank can register free_count alongside occupied.
module parking_spot_cell
    import parking_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               tick,
    input  logic [TIME_W-1:0]  now,
    input  logic [2:0]         vehicle_size,
    input  logic               car_ev,
    input  logic               attempt_ev,
    input  logic               leave_ev,
    output logic               occupied,
    output logic               occupied_next,
    output logic               calculate_fare,
    output logic [TIME_W-1:0]  start_time,
    output logic [TIME_W-1:0]  final_time,
    output logic [LIGHT_W-1:0] light,
    output logic [2:0]         vsize
);

    spot_state_e        state_r, state_next_s;
    logic [TIME_W-1:0]  start_r, start_next_s;
    logic [TIME_W-1:0]  final_r, final_next_s;
    logic [LIGHT_W-1:0] light_r, light_next_s;
    logic [2:0]         vsize_r, vsize_next_s;
    logic               occupied_r, fare_r;

    // Next state and next stored values; only the event legal for the current state acts.
    always_comb begin
        state_next_s = state_r;
        start_next_s = start_r;
        final_next_s = final_r;
        vsize_next_s = vsize_r;
        light_next_s = light_r;
        case (state_r)
            ST_EMPTY: begin
                if (car_ev) begin
                    state_next_s = ST_OCCUPIED;
                    start_next_s = now;
                    final_next_s = {TIME_W{1'b0}};
                    vsize_next_s = vehicle_size;
                    light_next_s = size_bar(vehicle_size);
                end else begin
                    light_next_s = LIGHT_OFF;
                end
            end
            ST_OCCUPIED: begin
                if (attempt_ev) begin
                    state_next_s = ST_BILLING;
                    final_next_s = now;
                    light_next_s = LIGHT_ALL;
                end else begin
                    light_next_s = size_bar(vsize_r);
                end
            end
            ST_BILLING: begin
                if (leave_ev) begin
                    state_next_s = ST_EMPTY;
                    start_next_s = {TIME_W{1'b0}};
                    final_next_s = {TIME_W{1'b0}};
                    vsize_next_s = 3'b000;
                    light_next_s = LIGHT_OFF;
                end else if (tick) begin
                    light_next_s = ~light_r;
                end else begin
                    light_next_s = light_r;
                end
            end
            default: begin
                // Unused encoding 2'd3 falls back to a clean EMPTY cell.
                state_next_s = ST_EMPTY;
                start_next_s = {TIME_W{1'b0}};
                final_next_s = {TIME_W{1'b0}};
                vsize_next_s = 3'b000;
                light_next_s = LIGHT_OFF;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r    <= ST_EMPTY;
            start_r    <= {TIME_W{1'b0}};
            final_r    <= {TIME_W{1'b0}};
            vsize_r    <= 3'b000;
            light_r    <= LIGHT_OFF;
            occupied_r <= 1'b0;
            fare_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            start_r    <= start_next_s;
            final_r    <= final_next_s;
            vsize_r    <= vsize_next_s;
            light_r    <= light_next_s;
            occupied_r <= (state_next_s != ST_EMPTY);
            fare_r     <= (state_next_s == ST_BILLING);
        end
    end

    assign occupied_next  = resetn && (state_next_s != ST_EMPTY);
    assign occupied       = occupied_r;
    assign calculate_fare = fare_r;
    assign start_time     = start_r;
    assign final_time     = final_r;
    assign light          = light_r;
    assign vsize          = vsize_r;

endmodule

// File: rtl/parking_spot_bank.sv
// Bank of NUM_SPOTS parking cells with a shared tick-driven time base, per-bit rising-edge
// detection of the datapath levels, a registered free-spot count and flattened output buses.
module parking_spot_bank
    import parking_pkg::*;
(
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          tick,
    input  logic [NUM_SPOTS-1:0]          car_in,
    input  logic [NUM_SPOTS-1:0]          attempt,
    input  logic [NUM_SPOTS-1:0]          leave_to_spots,
    input  logic [2:0]                    vehicle_size,
    output logic [NUM_SPOTS-1:0]          occupied,
    output logic [NUM_SPOTS-1:0]          calculate_fare,
    output logic [NUM_SPOTS*TIME_W-1:0]   start_flat,
    output logic [NUM_SPOTS*TIME_W-1:0]   final_flat,
    output logic [NUM_SPOTS*LIGHT_W-1:0]  light_flat,
    output logic [NUM_SPOTS*3-1:0]        vsize_flat,
    output logic [3:0]                    free_count,
    output logic [TIME_W-1:0]             now
);

    logic [TIME_W-1:0]    now_r;
    logic [NUM_SPOTS-1:0] car_cur_r, car_prev_r;
    logic [NUM_SPOTS-1:0] att_cur_r, att_prev_r;
    logic [NUM_SPOTS-1:0] lv_cur_r, lv_prev_r;
    logic [NUM_SPOTS-1:0] car_ev_s, att_ev_s, lv_ev_s;
    logic [NUM_SPOTS-1:0] occ_next_s;
    logic [3:0]           free_next_s;
    logic [3:0]           free_count_r;

    // Time base and edge-detector registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            now_r      <= {TIME_W{1'b0}};
            car_cur_r  <= {NUM_SPOTS{1'b0}};
            car_prev_r <= {NUM_SPOTS{1'b0}};
            att_cur_r  <= {NUM_SPOTS{1'b0}};
            att_prev_r <= {NUM_SPOTS{1'b0}};
            lv_cur_r   <= {NUM_SPOTS{1'b0}};
            lv_prev_r  <= {NUM_SPOTS{1'b0}};
        end else begin
            now_r      <= tick ? now_r + TIME_W'(1) : now_r;
            car_cur_r  <= car_in;
            car_prev_r <= car_cur_r;
            att_cur_r  <= attempt;
            att_prev_r <= att_cur_r;
            lv_cur_r   <= leave_to_spots;
            lv_prev_r  <= lv_cur_r;
        end
    end

    assign car_ev_s = car_cur_r & ~car_prev_r;
    assign att_ev_s = att_cur_r & ~att_prev_r;
    assign lv_ev_s  = lv_cur_r  & ~lv_prev_r;

    genvar g;
    generate
        for (g = 0; g < NUM_SPOTS; g++) begin : g_cell
            parking_spot_cell u_cell (
                .clock          (clock),
                .resetn         (resetn),
                .tick           (tick),
                .now            (now_r),
                .vehicle_size   (vehicle_size),
                .car_ev         (car_ev_s[g]),
                .attempt_ev     (att_ev_s[g]),
                .leave_ev       (lv_ev_s[g]),
                .occupied       (occupied[g]),
                .occupied_next  (occ_next_s[g]),
                .calculate_fare (calculate_fare[g]),
                .start_time     (start_flat[g*TIME_W +: TIME_W]),
                .final_time     (final_flat[g*TIME_W +: TIME_W]),
                .light          (light_flat[g*LIGHT_W +: LIGHT_W]),
                .vsize          (vsize_flat[g*3 +: 3])
            );
        end
    endgenerate

    // Count the cells that will be EMPTY after this edge.
    always_comb begin
        free_next_s = 4'd0;
        for (int i = 0; i < NUM_SPOTS; i++) begin
            free_next_s = free_next_s + {3'd0, ~occ_next_s[i]};
        end
    end

    // Free-spot count register, aligned with the cells' occupied registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            free_count_r <= 4'd9;
        end else begin
            free_count_r <= free_next_s;
        end
    end

    assign free_count = free_count_r;
    assign now        = now_r;

endmodule

// File: tb/tb_parking_spot_bank.sv
// Self-checking bench: a per-spot behavioural model checked every cycle plus directed literal checks.
module tb_parking_spot_bank;

    logic        clock = 1'b0;
    logic        resetn, tick;
    logic [8:0]  car_in, attempt, leave_to_spots;
    logic [2:0]  vehicle_size;
    logic [8:0]  occupied, calculate_fare;
    logic [80:0] start_flat, final_flat;
    logic [89:0] light_flat;
    logic [26:0] vsize_flat;
    logic [3:0]  free_count;
    logic [8:0]  now;

    int checks = 0;
    int failures = 0;

    parking_spot_bank dut (
        .clock(clock), .resetn(resetn), .tick(tick), .car_in(car_in), .attempt(attempt),
        .leave_to_spots(leave_to_spots), .vehicle_size(vehicle_size), .occupied(occupied),
        .calculate_fare(calculate_fare), .start_flat(start_flat), .final_flat(final_flat),
        .light_flat(light_flat), .vsize_flat(vsize_flat), .free_count(free_count), .now(now)
    );

    always #5 clock = ~clock;

    // Behavioural model: 0 = empty, 1 = parked, 2 = paying.
    int         m_st[9];
    int         m_start[9], m_final[9], m_size[9];
    bit         m_on[9];
    int         m_now;
    bit [8:0]   m_car_seen, m_att_seen, m_lv_seen, m_car_old, m_att_old, m_lv_old;
    bit         m_valid = 1'b0;

    always @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 9; i++) begin
                m_st[i] = 0; m_start[i] = 0; m_final[i] = 0; m_size[i] = 0; m_on[i] = 1'b0;
            end
            m_now = 0;
            m_car_seen = '0; m_att_seen = '0; m_lv_seen = '0;
            m_car_old = '0; m_att_old = '0; m_lv_old = '0;
            m_valid = 1'b1;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (m_st[i] == 0 && m_car_seen[i] && !m_car_old[i]) begin
                    m_st[i] = 1; m_start[i] = m_now; m_final[i] = 0; m_size[i] = int'(vehicle_size);
                end else if (m_st[i] == 1 && m_att_seen[i] && !m_att_old[i]) begin
                    m_st[i] = 2; m_final[i] = m_now; m_on[i] = 1'b1;
                end else if (m_st[i] == 2 && m_lv_seen[i] && !m_lv_old[i]) begin
                    m_st[i] = 0; m_start[i] = 0; m_final[i] = 0; m_size[i] = 0;
                end else if (m_st[i] == 2 && tick) begin
                    m_on[i] = !m_on[i];
                end
            end
            if (tick) m_now = (m_now + 1) % 512;
            m_car_old = m_car_seen; m_att_old = m_att_seen; m_lv_old = m_lv_seen;
            m_car_seen = car_in; m_att_seen = attempt; m_lv_seen = leave_to_spots;
        end
    end

    function automatic logic [9:0] bar_of(input int size);
        case (size)
            1:       return 10'h003;
            2:       return 10'h00F;
            4:       return 10'h03F;
            default: return 10'h001;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            logic [8:0]  e_occ, e_fare;
            logic [80:0] e_start, e_final;
            logic [89:0] e_light;
            logic [26:0] e_vs;
            int          e_free;
            e_free = 0;
            for (int i = 0; i < 9; i++) begin
                e_occ[i]            = (m_st[i] != 0);
                e_fare[i]           = (m_st[i] == 2);
                e_start[i*9 +: 9]   = 9'(m_start[i]);
                e_final[i*9 +: 9]   = 9'(m_final[i]);
                e_vs[i*3 +: 3]      = 3'(m_size[i]);
                e_light[i*10 +: 10] = (m_st[i] == 0) ? 10'h000 :
                                      (m_st[i] == 1) ? bar_of(m_size[i]) :
                                      (m_on[i] ? 10'h3FF : 10'h000);
                if (m_st[i] == 0) e_free++;
            end
            cmp("m_occupied", 96'(occupied), 96'(e_occ));
            cmp("m_fare", 96'(calculate_fare), 96'(e_fare));
            cmp("m_start", 96'(start_flat), 96'(e_start));
            cmp("m_final", 96'(final_flat), 96'(e_final));
            cmp("m_light", 96'(light_flat), 96'(e_light));
            cmp("m_vsize", 96'(vsize_flat), 96'(e_vs));
            cmp("m_free", 96'(free_count), 96'(e_free));
            cmp("m_now", 96'(now), 96'(m_now));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        resetn = 1'b0; tick = 1'b0; car_in = '0; attempt = '0; leave_to_spots = '0;
        vehicle_size = 3'b001;
        cyc(2);
        cmp("rst_free", 96'(free_count), 96'(9));
        cmp("rst_occ", 96'(occupied), 96'(0));
        resetn = 1'b1;

        // 1: five ticks from reset
        tick = 1'b1; cyc(5); tick = 1'b0; cyc(1);
        cmp("t1_now", 96'(now), 96'(5));
        cmp("t1_light", 96'(light_flat), 96'(0));
        cmp("t1_free", 96'(free_count), 96'(9));

        // 2: park a van in spot 2 at now=3 with a held level
        resetn = 1'b0; cyc(1); resetn = 1'b1;
        tick = 1'b1; cyc(3); tick = 1'b0;
        car_in = 9'b000000100; vehicle_size = 3'b010;
        cyc(1);
        cmp("t2_lat1", 96'(occupied), 96'(0));
        cyc(1);
        cmp("t2_lat2", 96'(occupied), 96'(9'b000000100));
        cyc(2); car_in = '0; cyc(1);
        cmp("t2_start", 96'(start_flat[18 +: 9]), 96'(3));
        cmp("t2_vsize", 96'(vsize_flat[6 +: 3]), 96'(3'b010));
        cmp("t2_light", 96'(light_flat[20 +: 10]), 96'(10'b0000001111));
        cmp("t2_free", 96'(free_count), 96'(8));

        // 3: bill at now=20, watch the LEDs toggle, then leave
        tick = 1'b1; cyc(17); tick = 1'b0;
        attempt = 9'b000000100; cyc(1); attempt = '0; cyc(1);
        cmp("t3_fare", 96'(calculate_fare), 96'(9'b000000100));
        cmp("t3_final", 96'(final_flat[18 +: 9]), 96'(20));
        cmp("t3_light_on", 96'(light_flat[20 +: 10]), 96'(10'h3FF));
        tick = 1'b1; cyc(1); tick = 1'b0;
        cmp("t3_light_off", 96'(light_flat[20 +: 10]), 96'(10'h000));
        tick = 1'b1; cyc(1); tick = 1'b0;
        cmp("t3_light_on2", 96'(light_flat[20 +: 10]), 96'(10'h3FF));
        leave_to_spots = 9'b000000100; cyc(1); leave_to_spots = '0; cyc(1);
        cmp("t3_occ", 96'(occupied), 96'(0));
        cmp("t3_start", 96'(start_flat), 96'(0));
        cmp("t3_free", 96'(free_count), 96'(9));

        // 4: illegal events on spot 5
        attempt = 9'b000100000; cyc(1); attempt = '0; cyc(2);
        cmp("t4_att_empty", 96'({occupied, calculate_fare}), 96'(0));
        vehicle_size = 3'b100;
        car_in = 9'b000100000; cyc(1); car_in = '0; cyc(1);
        leave_to_spots = 9'b000100000; cyc(1); leave_to_spots = '0; cyc(2);
        cmp("t4_lv_occ", 96'(occupied), 96'(9'b000100000));
        cmp("t4_lv_fare", 96'(calculate_fare), 96'(0));
        cmp("t4_bus_light", 96'(light_flat[50 +: 10]), 96'(10'b0000111111));

        // 5: wrap-around stay on spot 1 (now is 22 here)
        tick = 1'b1; cyc(488); tick = 1'b0;
        cmp("t5_now510", 96'(now), 96'(510));
        car_in = 9'b000000010; cyc(1); car_in = '0; cyc(1);
        tick = 1'b1; cyc(10); tick = 1'b0;
        attempt = 9'b000000010; cyc(1); attempt = '0; cyc(1);
        cmp("t5_start", 96'(start_flat[9 +: 9]), 96'(510));
        cmp("t5_final", 96'(final_flat[9 +: 9]), 96'(8));
        cmp("t5_elapsed", 96'((final_flat[9 +: 9] - start_flat[9 +: 9]) & 9'h1FF), 96'(10));

        // 6: simultaneous events on different spots, then reset mid-billing
        car_in = 9'b100000000; cyc(1); car_in = '0; cyc(1);
        car_in = 9'b000000001; attempt = 9'b100000000; cyc(1);
        car_in = '0; attempt = '0; cyc(1);
        cmp("t6_occ", 96'(occupied), 96'(9'b100100011));
        cmp("t6_fare", 96'(calculate_fare), 96'(9'b100000010));
        cmp("t6_free", 96'(free_count), 96'(5));
        resetn = 1'b0; cyc(1); resetn = 1'b1;
        cmp("t6_rst_occ", 96'({occupied, calculate_fare}), 96'(0));
        cmp("t6_rst_bus", 96'(|{start_flat, final_flat, light_flat, vsize_flat}), 96'(0));
        cmp("t6_rst_free", 96'(free_count), 96'(9));
        cmp("t6_rst_now", 96'(now), 96'(0));
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
